// File: rtl/adc_frame_reader.sv
// Reads one multi-byte sample per ADC data-ready edge over an external SPI master, scanning channels round-robin.
// Optional feature: define ADC_FRAME_READER_TIMESTAMP_EN to add a 16-bit DRDY timestamp output.
module adc_frame_reader #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DATA_BYTES   = 3,
  parameter logic [4:0]  CMD_PREFIX   = 5'b00001
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    drdy_n_i,
  output logic                    spi_start_o,
  output logic [7:0]              spi_tx_o,
  input  logic                    spi_done_i,
  input  logic [7:0]              spi_rx_i,
  output logic [8*DATA_BYTES-1:0] sample_o,
  output logic [2:0]              channel_o,
  output logic                    sample_valid_o,
  input  logic                    sample_ready_i,
  output logic                    overrun_o
`ifdef ADC_FRAME_READER_TIMESTAMP_EN
  ,
  output logic [15:0]             timestamp_o
`endif
);

  localparam int unsigned SAMPLE_W = 8 * DATA_BYTES;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned CH_W     = 3;

  typedef enum logic [2:0] {
    IDLE, WAIT_DRDY, CMD, CMD_WAIT, DATA, DATA_WAIT, OUTPUT
  } state_t;

  state_t              state, state_nxt;
  logic                drdy_meta, drdy_sync, drdy_last;
  logic                pending;
  logic                fall, wait_clr, idle_clr;
  logic                abort, abort_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [CH_W-1:0]     channel, channel_nxt;
  logic [SAMPLE_W-1:0] asm_q, asm_nxt, asm_shift;
  logic                frame_done;
  logic                start_nxt, valid_nxt;
  logic [7:0]          tx_nxt;
  logic [SAMPLE_W-1:0] sample_nxt;
  logic [CH_W-1:0]     chan_out_nxt;

  assign fall       = drdy_last & ~drdy_sync;
  assign wait_clr   = (state == WAIT_DRDY) && enable_i && pending;
  assign idle_clr   = (state == IDLE) && !enable_i;
  assign asm_shift  = SAMPLE_W'({asm_q, spi_rx_i});
  assign frame_done = (state == DATA_WAIT) && spi_done_i && enable_i && !abort
                      && (cnt == CNT_W'(DATA_BYTES - 1));

  // DRDY synchronizer, edge capture and sticky overrun
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      drdy_meta <= 1'b1;
      drdy_sync <= 1'b1;
      drdy_last <= 1'b1;
      pending   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      drdy_meta <= drdy_n_i;
      drdy_sync <= drdy_meta;
      drdy_last <= drdy_sync;
      if (idle_clr) begin
        pending   <= 1'b0;
        overrun_o <= 1'b0;
      end else begin
        if (fall)          pending <= 1'b1;
        else if (wait_clr) pending <= 1'b0;
        if (fall && pending && !wait_clr) overrun_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= IDLE;
      abort          <= 1'b0;
      cnt            <= '0;
      channel        <= '0;
      asm_q          <= '0;
      spi_start_o    <= 1'b0;
      spi_tx_o       <= 8'h00;
      sample_o       <= '0;
      channel_o      <= '0;
      sample_valid_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      abort          <= abort_nxt;
      cnt            <= cnt_nxt;
      channel        <= channel_nxt;
      asm_q          <= asm_nxt;
      spi_start_o    <= start_nxt;
      spi_tx_o       <= tx_nxt;
      sample_o       <= sample_nxt;
      channel_o      <= chan_out_nxt;
      sample_valid_o <= valid_nxt;
    end
  end

  // Next state; start is registered so it is high exactly during CMD/DATA
  always_comb begin
    state_nxt    = state;
    abort_nxt    = abort;
    cnt_nxt      = cnt;
    channel_nxt  = channel;
    asm_nxt      = asm_q;
    start_nxt    = 1'b0;
    tx_nxt       = spi_tx_o;
    sample_nxt   = sample_o;
    chan_out_nxt = channel_o;
    valid_nxt    = sample_valid_o;
    case (state)
      IDLE: begin
        abort_nxt = 1'b0;
        if (enable_i) state_nxt = WAIT_DRDY;
        else          channel_nxt = '0;
      end
      WAIT_DRDY: begin
        if (!enable_i) begin
          state_nxt = IDLE;
        end else if (pending) begin
          state_nxt = CMD;
          start_nxt = 1'b1;
          tx_nxt    = {CMD_PREFIX, channel};
          cnt_nxt   = '0;
          asm_nxt   = '0;
        end
      end
      CMD, DATA: begin
        if (!enable_i) abort_nxt = 1'b1;
        state_nxt = (state == CMD) ? CMD_WAIT : DATA_WAIT;
      end
      CMD_WAIT, DATA_WAIT: begin
        if (!enable_i) abort_nxt = 1'b1;
        if (spi_done_i) begin
          if (abort || !enable_i) begin
            state_nxt = IDLE;
          end else if (frame_done) begin
            state_nxt    = OUTPUT;
            sample_nxt   = asm_shift;
            chan_out_nxt = channel;
            valid_nxt    = 1'b1;
          end else begin
            state_nxt = DATA;
            start_nxt = 1'b1;
            tx_nxt    = 8'h00;
            if (state == DATA_WAIT) begin
              asm_nxt = asm_shift;
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
      end
      OUTPUT: begin
        if (sample_valid_o && sample_ready_i) begin
          valid_nxt   = 1'b0;
          channel_nxt = (channel == CH_W'(NUM_CHANNELS - 1)) ? '0 : channel + CH_W'(1);
          state_nxt   = WAIT_DRDY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ADC_FRAME_READER_TIMESTAMP_EN
  logic [15:0] ts_count, ts_cap, ts_frame;

  // Capture time of the edge that sets pending; carry it with the frame it starts
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ts_count    <= '0;
      ts_cap      <= '0;
      ts_frame    <= '0;
      timestamp_o <= '0;
    end else begin
      ts_count <= ts_count + 16'd1;
      if (fall && !idle_clr && (!pending || wait_clr)) ts_cap <= ts_count;
      if (wait_clr)   ts_frame    <= ts_cap;
      if (frame_done) timestamp_o <= ts_frame;
    end
  end
`endif

endmodule

// File: doc/adc_frame_reader.md
ADC_FRAME_READER -- requirements
Module: adc_frame_reader

Interface
REQ-001 Parameter NUM_CHANNELS, default 4, meaning channels scanned round-robin (1..8).
REQ-002 Parameter DATA_BYTES, default 3, meaning data bytes per sample (1..4).
REQ-003 Parameter CMD_PREFIX, default 5'b00001, meaning upper 5 bits of the read command byte.
REQ-004 Port clock_i  in  1  sole clock; all flops clocked on posedge clock_i.
REQ-005 Port reset_i  in  1  reset, asynchronous and active-high.
REQ-006 Port enable_i  in  1  level; high permits conversion reads.
REQ-007 Port drdy_n_i  in  1  ADC data-ready, active-low, asynchronous to clock_i.
REQ-008 Port spi_start_o  out  1  one-cycle transfer request to the SPI master.
REQ-009 Port spi_tx_o  out  8  byte for the SPI master to transmit; stable while a transfer is outstanding.
REQ-010 Port spi_done_i  in  1  one-cycle transfer-complete pulse from the SPI master.
REQ-011 Port spi_rx_i  in  8  received byte; valid in the spi_done_i cycle.
REQ-012 Port sample_o  out  8*DATA_BYTES  assembled sample, first received byte in the MSBs.
REQ-013 Port channel_o  out  3  channel index of sample_o.
REQ-014 Port sample_valid_o, sample_ready_i  out/in  1 each  valid/ready output handshake.
REQ-015 Port overrun_o  out  1  sticky flag: a DRDY edge arrived while the previous one was still pending.

Function
REQ-016 drdy_n_i SHALL pass through a 2-flop synchronizer; a falling edge of the synchronized signal SHALL set a pending flag.
REQ-017 FSM states SHALL be IDLE, WAIT_DRDY, CMD, CMD_WAIT, DATA, DATA_WAIT, OUTPUT.
REQ-018 In IDLE, enable_i high SHALL move to WAIT_DRDY next cycle.
REQ-019 In WAIT_DRDY, pending high SHALL clear pending and move to CMD.
REQ-020 CMD SHALL assert spi_start_o for exactly one cycle with spi_tx_o = {CMD_PREFIX, channel[2:0]}, then move to CMD_WAIT.
REQ-021 CMD_WAIT and DATA_WAIT SHALL hold until spi_done_i; spi_rx_i in CMD_WAIT SHALL be discarded.
REQ-022 DATA SHALL pulse spi_start_o for one cycle with spi_tx_o = 8'h00; DATA_WAIT SHALL shift spi_rx_i into the assembly register on spi_done_i.
REQ-023 DATA_WAIT SHALL return to DATA until DATA_BYTES bytes are received, then move to OUTPUT.
REQ-024 spi_start_o SHALL never assert in a cycle where spi_done_i is high, nor before the previous transfer's done.
REQ-025 sample_valid_o SHALL rise the cycle after the final spi_done_i, with sample_o/channel_o loaded at the same edge.
REQ-026 sample_o, channel_o and sample_valid_o SHALL remain stable while sample_valid_o high and sample_ready_i low.
REQ-027 OUTPUT SHALL wait for sample_valid_o & sample_ready_i, then advance channel (NUM_CHANNELS-1 wraps to 0) and go to WAIT_DRDY.
REQ-028 A falling edge while pending is already high SHALL set overrun_o; an edge coinciding with the WAIT_DRDY clear SHALL re-set pending, not overrun.
REQ-029 enable_i low SHALL NOT abort an outstanding SPI transfer; the FSM SHALL finish it, discard the partial sample, and go to IDLE.
REQ-030 enable_i low in WAIT_DRDY or IDLE SHALL go/stay IDLE next cycle; pending, overrun_o and channel SHALL clear while in IDLE with enable_i low.
REQ-031 An already-valid sample SHALL stay valid through enable_i low until accepted.

Reset
REQ-032 reset_i SHALL immediately force state IDLE, spi_start_o 0, spi_tx_o 8'h00, sample_o 0, channel_o 0, sample_valid_o 0, overrun_o 0, pending 0, synchronizer flops 1.
REQ-033 reset_i during a transfer SHALL drop that transfer; no spi_start_o SHALL issue until reset deasserts and WAIT_DRDY sees a fresh edge.

Configuration
REQ-034 Macro ADC_FRAME_READER_TIMESTAMP_EN defined: a free-running 16-bit counter (reset 0, wraps) SHALL be latched at pending-set and presented on output timestamp_o[15:0] with sample_o, under the same stability rules.
REQ-035 Macro undefined: counter and timestamp_o port SHALL be absent; all other behaviour identical.

Verification
REQ-036 NUM_CHANNELS=4, DATA_BYTES=3, one DRDY edge, rx bytes 8'hAB,8'hCD,8'hEF -> command 8'h08, then two 8'h00 data bytes plus a third; sample_o=24'hABCDEF, channel_o=0, valid 1 cycle after the last done.
REQ-037 Four conversions, sample_ready_i tied high -> commands 8'h08,8'h09,8'h0A,8'h0B, then 8'h08 again (wrap).
REQ-038 sample_ready_i low 50 cycles -> sample_o stable throughout, no spi_start_o issued, accepted on ready.
REQ-039 Two DRDY edges during one frame -> overrun_o=1 and stays 1 until enable_i low in IDLE.
REQ-040 enable_i dropped after the second data byte's spi_start_o -> transfer completes, no sample_valid_o, IDLE; reset_i mid-DATA_WAIT -> all outputs at reset values immediately.
